// File: rtl/tick_ctl_pkg.sv
// Shared types and defaults for the tick rate controller.
package tick_ctl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_FREE  = 2'd0,
        MODE_BURST = 2'd1
    } mode_e;

    localparam int unsigned DEFAULT_HALF = 500_000;

    // Reserved mode codes fall back to free-running.
    function automatic mode_e decode_mode(input logic [1:0] m);
        return (m == 2'd1) ? MODE_BURST : MODE_FREE;
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Phase up-counter with synchronous clear; flags the last cycle of a phase.
module phase_counter #(
    parameter int unsigned CTR_W = 27
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic [CTR_W-1:0] i_limit,
    output logic             o_terminal_c
);

    logic [CTR_W-1:0] r_ctr;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_ctr <= '0;
        end else begin
            r_ctr <= r_ctr + CTR_W'(1);
        end
    end

    // Limit is never zero, so limit-1 never underflows.
    assign o_terminal_c = (r_ctr == (i_limit - CTR_W'(1)));

endmodule

// File: rtl/tick_rate_controller.sv
// Run/stop/burst sequencer for a programmable 50% duty clock divider with tick output.
module tick_rate_controller #(
    parameter int unsigned CTR_W        = 27,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned DEFAULT_HALF = tick_ctl_pkg::DEFAULT_HALF
) (
    input  logic             CLK100MHZ,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CTR_W-1:0] cfg_half,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             stop,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             done
);
    import tick_ctl_pkg::*;

    localparam logic [CTR_W-1:0] DEF_HALF = CTR_W'(DEFAULT_HALF);

    state_e           r_state, w_state_nxt;
    logic [CTR_W-1:0] r_sh_half, r_act_half, w_half_norm;
    mode_e            r_sh_mode, r_act_mode, w_eff_mode;
    logic [CNT_W-1:0] r_sh_count, r_act_count, w_eff_count;
    logic [CNT_W-1:0] r_remaining, w_rem_nxt;
    logic             r_cfg_ready, r_stop, r_clk_out, r_tick, r_busy, r_done;
    logic             w_clk_nxt, w_tick_nxt, w_done_nxt, w_stop_nxt, w_apply;
    logic             w_pending, w_cfg_fire, w_term_c, w_ctr_clr;

    assign w_pending   = ~r_cfg_ready;
    assign w_cfg_fire  = cfg_valid & r_cfg_ready;
    assign w_half_norm = (cfg_half == '0) ? CTR_W'(1) : cfg_half;
    // A pending shadow config governs a run started from IDLE.
    assign w_eff_mode  = w_pending ? r_sh_mode : r_act_mode;
    assign w_eff_count = w_pending ? r_sh_count : r_act_count;
    assign w_ctr_clr   = (r_state == ST_IDLE) || w_term_c;

    phase_counter #(.CTR_W(CTR_W)) u_phase (
        .clk          (CLK100MHZ),
        .reset        (reset),
        .i_clr        (w_ctr_clr),
        .i_limit      (r_act_half),
        .o_terminal_c (w_term_c)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_clk_nxt   = r_clk_out;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_stop_nxt  = r_stop;
        w_rem_nxt   = r_remaining;
        w_apply     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stop_nxt = 1'b0;
                w_apply    = w_pending;
                if (start) begin
                    if (w_eff_mode == MODE_BURST && w_eff_count == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_HIGH;
                        w_clk_nxt   = 1'b1;
                        w_tick_nxt  = 1'b1;
                        w_rem_nxt   = w_eff_count;
                    end
                end
            end
            ST_HIGH: begin
                if (stop) w_stop_nxt = 1'b1;
                if (w_term_c) begin
                    w_state_nxt = ST_LOW;
                    w_clk_nxt   = 1'b0;
                end
            end
            ST_LOW: begin
                if (stop) w_stop_nxt = 1'b1;
                if (w_term_c) begin
                    if (r_stop || stop ||
                        (r_act_mode == MODE_BURST && r_remaining <= CNT_W'(1))) begin
                        w_state_nxt = ST_IDLE;
                        w_clk_nxt   = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_stop_nxt  = 1'b0;
                    end else begin
                        // Period boundary: the only point a running config may change.
                        w_state_nxt = ST_HIGH;
                        w_clk_nxt   = 1'b1;
                        w_tick_nxt  = 1'b1;
                        if (w_pending) begin
                            w_apply   = 1'b1;
                            w_rem_nxt = r_sh_count;
                        end else if (r_act_mode == MODE_BURST) begin
                            w_rem_nxt = r_remaining - CNT_W'(1);
                        end
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_clk_out   <= 1'b0;
            r_tick      <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_stop      <= 1'b0;
            r_remaining <= '0;
            r_cfg_ready <= 1'b1;
            r_act_half  <= DEF_HALF;
            r_act_mode  <= MODE_FREE;
            r_act_count <= '0;
            r_sh_half   <= DEF_HALF;
            r_sh_mode   <= MODE_FREE;
            r_sh_count  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_clk_out   <= w_clk_nxt;
            r_tick      <= w_tick_nxt;
            r_done      <= w_done_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_stop      <= w_stop_nxt;
            r_remaining <= w_rem_nxt;
            if (w_apply) begin
                r_act_half  <= r_sh_half;
                r_act_mode  <= r_sh_mode;
                r_act_count <= r_sh_count;
                r_cfg_ready <= 1'b1;
            end else if (w_cfg_fire) begin
                r_sh_half   <= w_half_norm;
                r_sh_mode   <= decode_mode(cfg_mode);
                r_sh_count  <= cfg_count;
                r_cfg_ready <= 1'b0;
            end
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign clk_out   = r_clk_out;
    assign tick      = r_tick;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
